// File: rtl/score_bcd_display_pkg.sv
// Shared types and constant tables for the score BCD display block.
package score_bcd_display_pkg;

  localparam int unsigned SCORE_W    = 32;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned MAX_DIGITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; codes 10..15 never occur in BCD and show blank
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Largest displayable value per digit count; 10 digits cover the full 32-bit range
  localparam logic [MAX_DIGITS:0][SCORE_W-1:0] LIMIT_TABLE = {
    32'hFFFF_FFFF, 32'd999999999, 32'd99999999, 32'd9999999, 32'd999999,
    32'd99999, 32'd9999, 32'd999, 32'd99, 32'd9, 32'd0
  };

  function automatic logic [SCORE_W-1:0] score_limit(input int unsigned digits);
    return LIMIT_TABLE[4'(digits)];
  endfunction

endpackage

// File: rtl/score_bcd_display_if.sv
// Score input and display outputs of the BCD display block.
interface score_bcd_display_if
  import score_bcd_display_pkg::*;
#(
  parameter int unsigned DIGITS = 8
);

  logic [SCORE_W-1:0]      score_in;
  logic [4*DIGITS-1:0]     bcd_out;
  logic                    bcd_valid;
  logic                    busy;
  logic                    overflow;
  logic [SEG_W*DIGITS-1:0] seg_out;

  modport master (
    output score_in,
    input  bcd_out, bcd_valid, busy, overflow, seg_out
  );

  modport slave (
    input  score_in,
    output bcd_out, bcd_valid, busy, overflow, seg_out
  );

endinterface

// File: rtl/score_bcd_display_seg7_decoder.sv
// One BCD digit to active-low seven-segment pattern, with forced blank.
module seg7_decoder
  import score_bcd_display_pkg::*;
(
  input  logic [3:0]       bcd_i,
  input  logic             blank_i,
  output logic [SEG_W-1:0] seg_o_c
);

  // Table lookup, overridden by blanking
  always_comb begin
    seg_o_c = SEG_TABLE[bcd_i];
    if (blank_i) seg_o_c = SEG_BLANK;
  end

endmodule

// File: rtl/score_bcd_display.sv
// Binary score to packed BCD (sequential double-dabble) and HEX display driver.
module score_bcd_display
  import score_bcd_display_pkg::*;
#(
  parameter int unsigned DIGITS        = 8,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input logic            clock,
  input logic            resetn,
  score_bcd_display_if.slave bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + SCORE_W;
  localparam int unsigned SGO_W = SEG_W * DIGITS;
  localparam logic [SCORE_W-1:0] LIMIT = score_limit(DIGITS);

  // Reset display: digit0 shows "0", upper digits blank or "0"
  function automatic logic [SGO_W-1:0] seg_reset_val();
    logic [SGO_W-1:0] v;
    v = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      v[SEG_W*k +: SEG_W] = (k == 0 || !BLANK_LEADING) ? SEG_TABLE[0] : SEG_BLANK;
    end
    return v;
  endfunction

  localparam logic [SGO_W-1:0] SEG_RST = seg_reset_val();

  state_e              state_q;
  logic [SR_W-1:0]     sr_q;
  logic [SR_W-1:0]     sr_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [SCORE_W-1:0]  last_q;
  logic                ovf_pend_q;
  logic [BCD_W-1:0]    bcd_q;
  logic                valid_q;
  logic                busy_q;
  logic                ovf_q;
  logic [SGO_W-1:0]    seg_q;

  logic [SCORE_W-1:0]  score_sat_c;
  logic                ovf_c;
  logic [DIGITS-1:0]   blank_c;
  logic [SGO_W-1:0]    seg_c;

  // Clamp the incoming score to what the displays can show
  always_comb begin
    ovf_c       = (bus.score_in > LIMIT);
    score_sat_c = ovf_c ? LIMIT : bus.score_in;
  end

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left
  always_comb begin
    logic [SR_W-1:0] adj;
    adj = sr_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (sr_q[SCORE_W + 4*k +: 4] >= 4'd5) begin
        adj[SCORE_W + 4*k +: 4] = sr_q[SCORE_W + 4*k +: 4] + 4'd3;
      end
    end
    sr_d = adj << 1;
  end

  // Leading-zero blanking: digit k blanks when it and every higher digit are zero
  always_comb begin
    logic zero_above;
    blank_c    = '0;
    zero_above = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      zero_above = zero_above && (sr_q[SCORE_W + 4*k +: 4] == 4'd0);
      blank_c[k] = BLANK_LEADING && zero_above;
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
    seg7_decoder u_dec (
      .bcd_i   (sr_q[SCORE_W + 4*g +: 4]),
      .blank_i (blank_c[g]),
      .seg_o_c (seg_c[SEG_W*g +: SEG_W])
    );
  end

  // Conversion sequencer and registered display outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      seg_q      <= SEG_RST;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.score_in != last_q) begin
            last_q     <= bus.score_in;
            sr_q       <= {{BCD_W{1'b0}}, score_sat_c};
            ovf_pend_q <= ovf_c;
            cnt_q      <= CNT_W'(SCORE_W);
            busy_q     <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          bcd_q   <= sr_q[SR_W-1:SCORE_W];
          ovf_q   <= ovf_pend_q;
          seg_q   <= seg_c;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.bcd_out   = bcd_q;
  assign bus.bcd_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.overflow  = ovf_q;
  assign bus.seg_out   = seg_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Bench for score_bcd_display: arithmetic reference model plus directed scenarios.
module tb_score_bcd_display;

  localparam int unsigned ND    = 8;
  localparam int unsigned LIM   = 99999999;
  localparam int unsigned LAT   = 33;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] score = 32'd0;

  int pass_cnt = 0;
  int total_cnt = 0;

  score_bcd_display_if #(.DIGITS(ND)) bus_a ();
  score_bcd_display_if #(.DIGITS(ND)) bus_b ();

  assign bus_a.score_in = score;
  assign bus_b.score_in = score;

  score_bcd_display #(.DIGITS(ND), .BLANK_LEADING(1'b1)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus_a)
  );

  score_bcd_display #(.DIGITS(ND), .BLANK_LEADING(1'b0)) dut_nb (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] seg_pat(input int unsigned d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [31:0] bcd_of(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < int'(ND); k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [55:0] seg_of(input int unsigned v, input bit bl);
    logic [55:0] r;
    longint unsigned p;
    r = '0;
    p = 1;
    for (int k = 0; k < int'(ND); k++) begin
      if (bl && k >= 1 && longint'(v) < p) r[7*k +: 7] = 7'h7F;
      else r[7*k +: 7] = seg_pat(int'((longint'(v) / p) % 10));
      p = p * 10;
    end
    return r;
  endfunction

  // Reference model: each conversion shows its (saturated) score LAT clocks after capture
  bit          m_busy = 0;
  bit          m_valid = 0;
  bit          m_ovf = 0;
  bit          m_ovf_pend = 0;
  int          m_rem = 0;
  int unsigned m_last = 0;
  int unsigned m_pend = 0;
  int unsigned m_disp = 0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_busy = 0; m_valid = 0; m_ovf = 0; m_ovf_pend = 0;
      m_rem = 0; m_last = 0; m_pend = 0; m_disp = 0;
    end else begin
      m_valid = 0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_disp  = m_pend;
          m_ovf   = m_ovf_pend;
          m_valid = 1;
          m_busy  = 0;
        end
      end else if (score != m_last) begin
        m_last     = score;
        m_ovf_pend = (score > LIM);
        m_pend     = m_ovf_pend ? LIM : score;
        m_busy     = 1;
        m_rem      = LAT;
      end
    end
  end

  // Every-cycle comparison of both DUTs against the model
  always @(negedge clock) begin
    check("busy",      64'(bus_a.busy),      64'(m_busy));
    check("valid",     64'(bus_a.bcd_valid), 64'(m_valid));
    check("bcd",       64'(bus_a.bcd_out),   64'(bcd_of(m_disp)));
    check("ovf",       64'(bus_a.overflow),  64'(m_ovf));
    check("seg",       64'(bus_a.seg_out),   64'(seg_of(m_disp, 1'b1)));
    check("nb_valid",  64'(bus_b.bcd_valid), 64'(m_valid));
    check("nb_bcd",    64'(bus_b.bcd_out),   64'(bcd_of(m_disp)));
    check("nb_seg",    64'(bus_b.seg_out),   64'(seg_of(m_disp, 1'b0)));
  end

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus_a.bcd_valid && n < 200);
    if (!bus_a.bcd_valid) check("valid_timeout", 64'(0), 64'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bcd"},   64'(bus_a.bcd_out),   64'(0));
    check({tag, "_valid"}, 64'(bus_a.bcd_valid), 64'(0));
    check({tag, "_busy"},  64'(bus_a.busy),      64'(0));
    check({tag, "_ovf"},   64'(bus_a.overflow),  64'(0));
    check({tag, "_seg"},   64'(bus_a.seg_out),   64'({{7{7'h7F}}, 7'b1000000}));
    check({tag, "_nbseg"}, 64'(bus_b.seg_out),   64'({8{7'b1000000}}));
  endtask

  initial begin
    int n;
    int pulses;
    int busy_hi;
    int t_first;
    int t_second;
    logic [31:0] v_first;
    logic [31:0] v_second;

    #1 resetn = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    resetn = 1'b1;
    @(negedge clock);
    check("idle_no_conv", 64'(bus_a.busy), 64'(0));

    // 0 -> 300: latency, value, blanking
    score = 32'd300;
    @(negedge clock);
    check("busy_rise", 64'(bus_a.busy), 64'(1));
    n = 1;
    while (!bus_a.bcd_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("latency", 64'(n - 1), 64'(33));
    check("bcd_300", 64'(bus_a.bcd_out), 64'(32'h0000_0300));
    check("seg_300", 64'(bus_a.seg_out), 64'({{5{7'h7F}}, 7'h30, 7'h40, 7'h40}));
    check("nbseg_300", 64'(bus_b.seg_out), 64'({{5{7'h40}}, 7'h30, 7'h40, 7'h40}));

    // Stable input: no further conversions
    pulses = 0;
    busy_hi = 0;
    repeat (1000) begin
      @(negedge clock);
      pulses += int'(bus_a.bcd_valid);
      busy_hi += int'(bus_a.busy);
    end
    check("stable_pulses", 64'(pulses), 64'(0));
    check("stable_busy", 64'(busy_hi), 64'(0));

    // All eight digits lit
    score = 32'd12345678;
    wait_valid(n);
    check("bcd_12345678", 64'(bus_a.bcd_out), 64'(32'h1234_5678));
    check("ovf_12345678", 64'(bus_a.overflow), 64'(0));
    check("seg_12345678", 64'(bus_a.seg_out),
          64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));

    // Saturation, then recovery
    score = 32'd100000000;
    wait_valid(n);
    check("bcd_sat", 64'(bus_a.bcd_out), 64'(32'h9999_9999));
    check("ovf_sat", 64'(bus_a.overflow), 64'(1));
    score = 32'd5;
    wait_valid(n);
    check("bcd_5", 64'(bus_a.bcd_out), 64'(32'h0000_0005));
    check("ovf_5", 64'(bus_a.overflow), 64'(0));
    check("seg_5", 64'(bus_a.seg_out), 64'({{7{7'h7F}}, 7'h12}));

    // Input changes mid-conversion: old value first, new value 34 clocks later
    score = 32'd300;
    repeat (11) @(negedge clock);
    score = 32'd600;
    pulses = 0; t_first = 0; t_second = 0; v_first = '0; v_second = '0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clock);
      if (bus_a.bcd_valid) begin
        pulses++;
        if (pulses == 1) begin t_first = c; v_first = bus_a.bcd_out; end
        if (pulses == 2) begin t_second = c; v_second = bus_a.bcd_out; end
      end
    end
    check("race_pulses", 64'(pulses), 64'(2));
    check("race_first", 64'(v_first), 64'(32'h0000_0300));
    check("race_second", 64'(v_second), 64'(32'h0000_0600));
    check("race_gap", 64'(t_second - t_first), 64'(34));

    // Asynchronous reset in the middle of a conversion
    score = 32'd42;
    repeat (10) @(negedge clock);
    #2 resetn = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clock);
    resetn = 1'b1;
    wait_valid(n);
    check("bcd_42", 64'(bus_a.bcd_out), 64'(32'h0000_0042));

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
